split_channels: RTL and testbench

Splits one interleaved feature stream into two parallel channel streams, the inverse of the left/right channel concatenation stage. Each input group is 2*HALF_LEN valid words: the first HALF_LEN are left-channel words, the next HALF_LEN are right-channel words. Left words are buffered internally; each right word is emitted alongside its matching left word as one aligned pair on data_lo/data_ro. The block sits between a merged-stream producer (concat/pool path) and per-channel consumers, and carries sop/eop/sof/eof framing across.

---
 rtl/split_channels_if.sv | 30 +++
 rtl/split_channels.sv | 161 ++++++++++++++++
 tb/tb_split_channels.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/split_channels_if.sv
// rtl/split_channels_if.sv - merged-stream input and paired-channel output bundle
// The master side drives the merged word stream; the slave side returns aligned channel pairs.
interface split_channels_if #(
   parameter int DATA_WIDTH = 8
);
   logic                         data_valid_i;
   logic signed [DATA_WIDTH-1:0] data_i;
   logic                         sop_i;
   logic                         eop_i;
   logic                         sof_i;
   logic                         eof_i;
   logic signed [DATA_WIDTH-1:0] data_lo;
   logic signed [DATA_WIDTH-1:0] data_ro;
   logic                         data_valid_o;
   logic                         sop_o;
   logic                         eop_o;
   logic                         sof_o;
   logic                         eof_o;
   logic                         err_o;

   modport master (
      output data_valid_i, data_i, sop_i, eop_i, sof_i, eof_i,
      input  data_lo, data_ro, data_valid_o, sop_o, eop_o, sof_o, eof_o, err_o
   );

   modport slave (
      input  data_valid_i, data_i, sop_i, eop_i, sof_i, eof_i,
      output data_lo, data_ro, data_valid_o, sop_o, eop_o, sof_o, eof_o, err_o
   );
endinterface

// File: rtl/split_channels.sv
// rtl/split_channels.sv - split interleaved left/right half-groups into aligned channel pairs
// Left half is buffered; each right word leaves together with its matching left word.
module split_channels #(
   parameter int DATA_WIDTH = 8,
   parameter int HALF_LEN   = 16
) (
   input  logic             clk,
   input  logic             reset,
   split_channels_if.slave  bus
);
   localparam int IDX_W = $clog2(2 * HALF_LEN);
   localparam int LB_W  = IDX_W - 1;
   localparam logic [IDX_W-1:0] IDX_HALF     = IDX_W'(HALF_LEN);
   localparam logic [IDX_W-1:0] IDX_FILL_END = IDX_W'(HALF_LEN - 1);
   localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(2 * HALF_LEN - 1);

   typedef enum logic {
      FILL_L = 1'b0,
      EMIT_R = 1'b1
   } state_t;

   state_t                       state_q, state_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic                         pend_sop_q, pend_sop_d;
   logic                         pend_sof_q, pend_sof_d;
   logic                         err_q, err_d;
   logic                         valid_q, valid_d;
   logic                         sop_q, sop_d;
   logic                         eop_q, eop_d;
   logic                         sof_q, sof_d;
   logic                         eof_q, eof_d;
   logic signed [DATA_WIDTH-1:0] lo_q, lo_d;
   logic signed [DATA_WIDTH-1:0] ro_q, ro_d;

   logic signed [DATA_WIDTH-1:0] lbuf [HALF_LEN];
   logic                         lbuf_we;
   logic [LB_W-1:0]              lbuf_waddr;
   logic signed [DATA_WIDTH-1:0] lbuf_rdata;
   logic                         sop_resync;
   logic                         eop_resync;

   // HALF_LEN is a power of two, so idx - HALF_LEN is just the low bits in EMIT_R
   assign lbuf_rdata = lbuf[idx_q[LB_W-1:0]];

   assign sop_resync = bus.data_valid_i && bus.sop_i && ((idx_q != '0) || bus.eop_i);
   assign eop_resync = bus.data_valid_i && bus.eop_i && !bus.sop_i && (idx_q != IDX_LAST);

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      pend_sop_d = pend_sop_q;
      pend_sof_d = pend_sof_q;
      err_d      = err_q;
      valid_d    = 1'b0;
      sop_d      = 1'b0;
      eop_d      = 1'b0;
      sof_d      = 1'b0;
      eof_d      = 1'b0;
      lo_d       = lo_q;
      ro_d       = ro_q;
      lbuf_we    = 1'b0;
      lbuf_waddr = idx_q[LB_W-1:0];

      if (sop_resync) begin
         // Abandon the partial group and restart it with this word as idx 0
         err_d      = 1'b1;
         lbuf_we    = 1'b1;
         lbuf_waddr = '0;
         idx_d      = IDX_W'(1);
         state_d    = FILL_L;
         pend_sop_d = 1'b1;
         pend_sof_d = bus.sof_i;
      end else if (bus.data_valid_i) begin
         if (state_q == FILL_L) begin
            lbuf_we = 1'b1;
            if (idx_q == '0) begin
               pend_sop_d = bus.sop_i;
               pend_sof_d = bus.sof_i;
            end
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_FILL_END) begin
               state_d = EMIT_R;
            end
         end else begin
            valid_d = 1'b1;
            lo_d    = lbuf_rdata;
            ro_d    = bus.data_i;
            if (idx_q == IDX_HALF) begin
               sop_d      = pend_sop_q;
               sof_d      = pend_sof_q;
               pend_sop_d = 1'b0;
               pend_sof_d = 1'b0;
            end
            if ((idx_q == IDX_LAST) || eop_resync) begin
               eop_d      = bus.eop_i;
               eof_d      = bus.eof_i;
               idx_d      = '0;
               state_d    = FILL_L;
               pend_sop_d = 1'b0;
               pend_sof_d = 1'b0;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end

         // Early end of group: close it out regardless of which half we were in
         if (eop_resync) begin
            err_d      = 1'b1;
            idx_d      = '0;
            state_d    = FILL_L;
            pend_sop_d = 1'b0;
            pend_sof_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= FILL_L;
         idx_q      <= '0;
         pend_sop_q <= 1'b0;
         pend_sof_q <= 1'b0;
         err_q      <= 1'b0;
         valid_q    <= 1'b0;
         sop_q      <= 1'b0;
         eop_q      <= 1'b0;
         sof_q      <= 1'b0;
         eof_q      <= 1'b0;
         lo_q       <= '0;
         ro_q       <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         pend_sop_q <= pend_sop_d;
         pend_sof_q <= pend_sof_d;
         err_q      <= err_d;
         valid_q    <= valid_d;
         sop_q      <= sop_d;
         eop_q      <= eop_d;
         sof_q      <= sof_d;
         eof_q      <= eof_d;
         lo_q       <= lo_d;
         ro_q       <= ro_d;
      end
   end

   always_ff @(posedge clk) begin
      if (lbuf_we) begin
         lbuf[lbuf_waddr] <= bus.data_i;
      end
   end

   assign bus.data_lo      = lo_q;
   assign bus.data_ro      = ro_q;
   assign bus.data_valid_o = valid_q;
   assign bus.sop_o        = sop_q;
   assign bus.eop_o        = eop_q;
   assign bus.sof_o        = sof_q;
   assign bus.eof_o        = eof_q;
   assign bus.err_o        = err_q;
endmodule

// File: tb/tb_split_channels.sv
// tb/tb_split_channels.sv - scoreboard bench for split_channels
// A word-level group model predicts pairs, timing and error flag; a monitor checks them.
module tb_split_channels;
   localparam int DW = 8;
   localparam int H  = 16;

   typedef struct {
      logic signed [DW-1:0] lo;
      logic signed [DW-1:0] ro;
      logic                 sop;
      logic                 eop;
      logic                 sof;
      logic                 eof;
      int                   cyc;
   } pair_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic mon_en = 1'b0;

   pair_t                exp_q[$];
   logic signed [DW-1:0] grp[$];
   logic                 pend_sop = 1'b0;
   logic                 pend_sof = 1'b0;
   logic                 err_exp = 1'b0;
   logic signed [DW-1:0] last_lo = '0;
   logic signed [DW-1:0] last_ro = '0;

   split_channels_if #(.DATA_WIDTH(DW)) bus();

   split_channels #(.DATA_WIDTH(DW), .HALF_LEN(H)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d required %0d", name, cyc, act, req);
      end
   endtask

   // Word-level model: a group is the list of accepted words; word k >= H pairs with word k-H
   task automatic model_word(input logic signed [DW-1:0] d, input logic sop, input logic eop,
                             input logic sof, input logic eof);
      int    k;
      pair_t p;
      k = grp.size();
      if (sop && (k != 0 || eop)) begin
         err_exp = 1'b1;
         grp.delete();
         grp.push_back(d);
         pend_sop = 1'b1;
         pend_sof = sof;
         return;
      end
      if (k == 0) begin
         pend_sop = sop;
         pend_sof = sof;
      end
      if (k >= H) begin
         p.lo  = grp[k-H];
         p.ro  = d;
         p.sop = (k == H) && pend_sop;
         p.sof = (k == H) && pend_sof;
         p.eop = eop;
         p.eof = (eop || k == 2*H-1) ? eof : 1'b0;
         p.cyc = cyc + 1;
         exp_q.push_back(p);
      end
      if (eop && k != 2*H-1) err_exp = 1'b1;
      if (eop || k == 2*H-1) begin
         grp.delete();
         pend_sop = 1'b0;
         pend_sof = 1'b0;
      end else begin
         grp.push_back(d);
      end
   endtask

   task automatic drive(input logic v, input logic signed [DW-1:0] d, input logic sop,
                        input logic eop, input logic sof, input logic eof);
      @(negedge clk);
      #1;
      reset            = 1'b0;
      bus.data_valid_i = v;
      if (v) begin
         bus.data_i = d;
         bus.sop_i  = sop;
         bus.eop_i  = eop;
         bus.sof_i  = sof;
         bus.eof_i  = eof;
         model_word(d, sop, eop, sof, eof);
      end else begin
         // framing and data are don't-care without valid
         bus.data_i = DW'($urandom);
         bus.sop_i  = 1'($urandom);
         bus.eop_i  = 1'($urandom);
         bus.sof_i  = 1'($urandom);
         bus.eof_i  = 1'($urandom);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      reset            = 1'b1;
      bus.data_valid_i = 1'b0;
      grp.delete();
      pend_sop = 1'b0;
      pend_sof = 1'b0;
      err_exp  = 1'b0;
      last_lo  = '0;
      last_ro  = '0;
   endtask

   task automatic send_group(input int base, input bit gaps);
      for (int i = 0; i < 2*H; i++) begin
         drive(1'b1, DW'(base + i), i == 0, i == 2*H-1, i == 0, i == 2*H-1);
         if (gaps) idle(1);
      end
   endtask

   initial begin : monitor
      pair_t p;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (bus.data_valid_o) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_pair", exp_q.size(), 1);
               end else begin
                  p = exp_q.pop_front();
                  check("pair_cycle", cyc, p.cyc);
                  check("data_lo", bus.data_lo, p.lo);
                  check("data_ro", bus.data_ro, p.ro);
                  check("sop_o", bus.sop_o, p.sop);
                  check("eop_o", bus.eop_o, p.eop);
                  check("sof_o", bus.sof_o, p.sof);
                  check("eof_o", bus.eof_o, p.eof);
                  last_lo = p.lo;
                  last_ro = p.ro;
               end
            end else begin
               check("idle_flags", {bus.sop_o, bus.eop_o, bus.sof_o, bus.eof_o}, 0);
               check("hold_lo", bus.data_lo, last_lo);
               check("hold_ro", bus.data_ro, last_ro);
               if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                  check("missing_pair", bus.data_valid_o, 1);
                  void'(exp_q.pop_front());
               end
            end
            check("err_o", bus.err_o, err_exp);
         end
      end
   end

   initial begin : stimulus
      logic sop_r, eop_r;
      reset            = 1'b1;
      bus.data_valid_i = 1'b0;
      bus.data_i       = '0;
      bus.sop_i        = 1'b0;
      bus.eop_i        = 1'b0;
      bus.sof_i        = 1'b0;
      bus.eof_i        = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", bus.data_valid_o, 0);
      check("rst_lo", bus.data_lo, 0);
      check("rst_ro", bus.data_ro, 0);
      check("rst_flags", {bus.sop_o, bus.eop_o, bus.sof_o, bus.eof_o}, 0);
      check("rst_err", bus.err_o, 0);
      mon_en = 1'b1;

      send_group(0, 1'b0);
      idle(2);
      send_group(0, 1'b1);
      idle(2);
      send_group(0, 1'b0);
      send_group(100, 1'b0);
      idle(2);

      // sop on word 5 of a group, then a clean group
      do_reset();
      for (int i = 0; i < 5; i++) drive(1'b1, DW'(i), i == 0, 1'b0, i == 0, 1'b0);
      send_group(50, 1'b0);
      idle(2);

      // eop on word 20, the next word starts a new group
      do_reset();
      for (int i = 0; i <= 20; i++) drive(1'b1, DW'(i), i == 0, i == 20, i == 0, i == 20);
      send_group(60, 1'b0);
      idle(2);

      // reset at word 18, leftover words, then a fresh group
      do_reset();
      for (int i = 0; i < 18; i++) drive(1'b1, DW'(i), i == 0, 1'b0, i == 0, 1'b0);
      do_reset();
      for (int i = 19; i < 32; i++) drive(1'b1, DW'(i), 1'b0, i == 31, 1'b0, i == 31);
      send_group(-20, 1'b0);
      idle(2);

      // randomized groups with gaps and occasional stray framing
      do_reset();
      for (int g = 0; g < 40; g++) begin
         for (int i = 0; i < 2*H; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            sop_r = (i == 0) || ($urandom_range(0, 99) == 0);
            eop_r = (i == 2*H-1) || ($urandom_range(0, 99) == 0);
            drive(1'b1, DW'($urandom), sop_r, eop_r, 1'($urandom), 1'($urandom));
         end
      end
      idle(4);
      check("queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
